// File: rtl/dff_pipe_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_hs_if
// Description : Valid/ready handshake bundle for dff_pipe_hs. The producer
//               side (in_*) and consumer side (out_*) travel together.
//               master = environment driving the pipe, slave = the pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface dff_pipe_hs_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/dff_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_hs
// Description : DEPTH-stage, WIDTH-bit register pipeline with per-stage valid
//               bits, valid/ready backpressure, bubble collapse, occupancy
//               count and synchronous flush. Outputs come straight from the
//               last stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe_hs #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  dff_pipe_hs_if.slave               hs,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // A stage can advance if the consumer is taking data or any stage at or
  // downstream of it is empty. Written as a reduction rather than a chain so
  // the ready vector has no bit-to-bit combinational dependency.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      assign rdy[i] = hs.out_ready | ~(&v_q[DEPTH-1:i]);
      if (i == 0) begin : g_head
        assign src_v[i] = hs.in_valid;
        assign src_d[i] = hs.in_data;
      end else begin : g_body
        assign src_v[i] = v_q[i-1];
        assign src_d[i] = d_q[i-1];
      end
    end
  endgenerate

  assign in_xfer  = hs.in_valid & rdy[0];
  assign out_xfer = v_q[DEPTH-1] & hs.out_ready;

  // Occupancy follows accepted words minus emitted words; saturation is
  // implicit because in_ready drops when every stage is valid.
  always_comb begin
    count_d = count_q;
    case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Stage registers: shift where ready, keep old data when a bubble moves in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RESET_VAL;
    end else if (flush_i) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RESET_VAL;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_q[i] <= src_v[i];
          if (src_v[i]) d_q[i] <= src_d[i];
        end
      end
    end
  end

  assign hs.in_ready  = rdy[0];
  assign hs.out_valid = v_q[DEPTH-1];
  assign hs.out_data  = d_q[DEPTH-1];
  assign count_o      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_pipe_hs
// Description : Directed bench for dff_pipe_hs, WIDTH=8, DEPTH=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe_hs;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] count;
  int         n_cmp;
  int         n_bad;

  dff_pipe_hs_if #(.WIDTH(8)) hs ();

  dff_pipe_hs #(
    .WIDTH    (8),
    .DEPTH    (3),
    .RESET_VAL(8'h00)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush_i(flush),
    .hs     (hs.slave),
    .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic ordy);
    hs.in_valid  = v;
    hs.in_data   = d;
    hs.out_ready = ordy;
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [7:0] od, input logic [1:0] c);
    chk({tag, "_ov"}, 32'(hs.out_valid), 32'(ov));
    if (ov) chk({tag, "_od"}, 32'(hs.out_data), 32'(od));
    chk({tag, "_cnt"}, 32'(count), 32'(c));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    #12;
    chk("rst_ov", 32'(hs.out_valid), 32'd0);
    chk("rst_od", 32'(hs.out_data), 32'h00);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_ir", 32'(hs.in_ready), 32'd1);
    rst = 1'b0;

    // 1: load 0x11 to the output with out_ready low, then async reset
    drive(1'b1, 8'h11, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick(); tick();
    expect_out("t1_load", 1'b1, 8'h11, 2'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_ov", 32'(hs.out_valid), 32'd0);
    chk("t1_async_od", 32'(hs.out_data), 32'h00);
    chk("t1_async_cnt", 32'(count), 32'd0);
    chk("t1_async_ir", 32'(hs.in_ready), 32'd1);
    #2 rst = 1'b0;

    // 2: streaming with out_ready high
    drive(1'b1, 8'h01, 1'b1); tick(); expect_out("t2_e1", 1'b0, 8'h00, 2'd1);
    drive(1'b1, 8'h02, 1'b1); tick(); expect_out("t2_e2", 1'b0, 8'h00, 2'd2);
    drive(1'b1, 8'h03, 1'b1); tick(); expect_out("t2_e3", 1'b1, 8'h01, 2'd3);
    drive(1'b1, 8'h04, 1'b1); tick(); expect_out("t2_e4", 1'b1, 8'h02, 2'd3);
    drive(1'b0, 8'h00, 1'b1); tick(); expect_out("t2_e5", 1'b1, 8'h03, 2'd2);
    tick(); expect_out("t2_e6", 1'b1, 8'h04, 2'd1);
    tick(); expect_out("t2_e7", 1'b0, 8'h00, 2'd0);

    // 3: backpressure fill, then drain with 0xA3 held by the producer
    drive(1'b1, 8'hA0, 1'b0); tick(); chk("t3_ir1", 32'(hs.in_ready), 32'd1);
    drive(1'b1, 8'hA1, 1'b0); tick(); chk("t3_ir2", 32'(hs.in_ready), 32'd1);
    drive(1'b1, 8'hA2, 1'b0); tick();
    chk("t3_ir3", 32'(hs.in_ready), 32'd0);
    expect_out("t3_full", 1'b1, 8'hA0, 2'd3);
    drive(1'b1, 8'hA3, 1'b0); tick();
    chk("t3_ir_stall", 32'(hs.in_ready), 32'd0);
    expect_out("t3_stall", 1'b1, 8'hA0, 2'd3);
    drive(1'b1, 8'hA3, 1'b1);
    #1 chk("t3_ir_rel", 32'(hs.in_ready), 32'd1);
    tick(); expect_out("t3_d1", 1'b1, 8'hA1, 2'd3);
    drive(1'b1, 8'hA4, 1'b1); tick(); expect_out("t3_d2", 1'b1, 8'hA2, 2'd3);
    drive(1'b0, 8'h00, 1'b1); tick(); expect_out("t3_d3", 1'b1, 8'hA3, 2'd2);
    tick(); expect_out("t3_d4", 1'b1, 8'hA4, 2'd1);
    tick(); expect_out("t3_d5", 1'b0, 8'h00, 2'd0);

    // 4: bubbles collapse while stalled
    drive(1'b1, 8'h55, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    drive(1'b1, 8'h66, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    expect_out("t4_bub", 1'b1, 8'h55, 2'd2);
    chk("t4_ir", 32'(hs.in_ready), 32'd1);

    // 5: fill, then simultaneous push/pop at full
    drive(1'b1, 8'h88, 1'b0); tick();
    expect_out("t5_full", 1'b1, 8'h55, 2'd3);
    chk("t5_ir", 32'(hs.in_ready), 32'd0);
    drive(1'b1, 8'h99, 1'b1); tick(); expect_out("t5_pp1", 1'b1, 8'h66, 2'd3);
    drive(1'b1, 8'h9A, 1'b1); tick(); expect_out("t5_pp2", 1'b1, 8'h88, 2'd3);
    drive(1'b0, 8'h00, 1'b1); tick(); expect_out("t5_pop", 1'b1, 8'h99, 2'd2);

    // 6: flush with a word presented in the same cycle
    drive(1'b1, 8'h77, 1'b0);
    flush = 1'b1;
    #1 chk("t6_ir_flush", 32'(hs.in_ready), 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    chk("t6_ov", 32'(hs.out_valid), 32'd0);
    chk("t6_od", 32'(hs.out_data), 32'h00);
    chk("t6_cnt", 32'(count), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no77", 32'(hs.out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
